// File: rtl/int_mul_iter_resp_pkg.sv
// Shared definitions for the iterative multiplier responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package int_mul_iter_resp_pkg;

    // Default operand width and derived stream widths
    localparam int DEF_NBITS = 32;
    localparam int REQ_W     = 2 * DEF_NBITS;
    localparam int RESP_W    = DEF_NBITS;

    // Shift-amount counter width; must hold p_nbits plus a final skip
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_CALC = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/int_mul_iter_resp_dpath.sv
// Multiplier datapath: operand registers, shift-and-add, zero-run skipping.
// Latency: one iteration per cycle while step is high; load takes one cycle.
// Backpressure: none internally; registers hold whenever load and step are low.
//
// Ports: clk, reset; load/step controls from the FSM; req_a/req_b operands;
// b_is_zero, b_lsb, cnt_done status to the FSM; result is the product so far.
module int_mul_iter_resp_dpath
    import int_mul_iter_resp_pkg::*;
#(
    parameter int p_nbits    = DEF_NBITS,
    parameter int p_max_skip = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               b_is_zero,
    output logic               b_lsb,
    output logic               cnt_done,
    output logic [p_nbits-1:0] result
);

    localparam logic [CNT_W-1:0] NBITS_C = CNT_W'(p_nbits);

    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;
    logic [p_nbits-1:0] result_reg;
    logic [CNT_W-1:0]   shamt_cnt;
    logic [CNT_W-1:0]   skip;

    // Trailing zeros of the low p_max_skip bits, saturating at p_max_skip
    // when that whole window is zero. Scanning from the top down leaves the
    // lowest set bit's index in skip.
    always_comb begin
        skip = CNT_W'(p_max_skip);
        for (int i = p_max_skip - 1; i >= 0; i--) begin
            if (b_reg[i]) skip = CNT_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            shamt_cnt  <= '0;
        end else if (load) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            result_reg <= '0;
            shamt_cnt  <= '0;
        end else if (step) begin
            if (b_reg[0]) begin
                result_reg <= result_reg + a_reg;
                a_reg      <= a_reg << 1;
                b_reg      <= b_reg >> 1;
                shamt_cnt  <= shamt_cnt + CNT_W'(1);
            end else begin
                a_reg      <= a_reg << skip;
                b_reg      <= b_reg >> skip;
                shamt_cnt  <= shamt_cnt + skip;
            end
        end
    end

    assign b_is_zero = (b_reg == '0);
    assign b_lsb     = b_reg[0];
    assign cnt_done  = (shamt_cnt >= NBITS_C);
    assign result    = result_reg;

endmodule

// File: rtl/int_mul_iter_resp.sv
// Iterative 32-bit multiplier responder returning the low half of op1*op2.
// Latency: 2 cycles (b=0) up to p_nbits+2 cycles (b all ones) to resp valid.
// Backpressure: one transaction in flight; result held in DONE until resp rdy.
//
// Ports: clk, reset (sync, active-high); reqstream_val/rdy/msg carrying
// {op1, op2}; respstream_val/rdy/msg carrying the registered product.
module int_mul_iter_resp
    import int_mul_iter_resp_pkg::*;
#(
    parameter int p_nbits    = DEF_NBITS,
    parameter int p_max_skip = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqstream_val,
    output logic                 reqstream_rdy,
    input  logic [2*p_nbits-1:0] reqstream_msg,
    output logic                 respstream_val,
    input  logic                 respstream_rdy,
    output logic [p_nbits-1:0]   respstream_msg
);

    state_t state, state_nxt;
    logic   load, step;
    logic   b_is_zero, b_lsb, cnt_done;

    always_ff @(posedge clk) begin
        if (reset) state <= STATE_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        reqstream_rdy  = 1'b0;
        respstream_val = 1'b0;
        load           = 1'b0;
        step           = 1'b0;
        case (state)
            STATE_IDLE: begin
                reqstream_rdy = 1'b1;
                if (reqstream_val) begin
                    load      = 1'b1;
                    state_nxt = STATE_CALC;
                end
            end
            STATE_CALC: begin
                if (b_is_zero || cnt_done) state_nxt = STATE_DONE;
                else                       step      = 1'b1;
            end
            STATE_DONE: begin
                respstream_val = 1'b1;
                if (respstream_rdy) state_nxt = STATE_IDLE;
            end
            default: state_nxt = STATE_IDLE;
        endcase
    end

    int_mul_iter_resp_dpath #(
        .p_nbits    (p_nbits),
        .p_max_skip (p_max_skip)
    ) u_dpath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .req_a     (reqstream_msg[2*p_nbits-1:p_nbits]),
        .req_b     (reqstream_msg[p_nbits-1:0]),
        .b_is_zero (b_is_zero),
        .b_lsb     (b_lsb),
        .cnt_done  (cnt_done),
        .result    (respstream_msg)
    );

    // b_lsb is exported for observability; the datapath decodes it itself
    logic unused_ok;
    assign unused_ok = b_lsb;

endmodule

// File: doc/int_mul_iter_resp.md
Name: int_mul_iter_resp

Overview:
- Iterative, variable-latency 32-bit integer multiplier that serves as the responder on the processor's multiplier port.
- Accepts a 64-bit request {op1, op2} on a val/rdy reqstream and returns the low 32 bits of op1*op2 on a val/rdy respstream.
- Handles one transaction at a time.
- Skips runs of zero bits in the multiplier operand to shorten latency.

Parameters:
- p_nbits, 32: operand/result width; request msg is 2*p_nbits.
- p_max_skip, 4: maximum zero bits skipped per cycle (power of 2, 1..8).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- reqstream_val  input  1  request valid
- reqstream_rdy  output  1  request ready
- reqstream_msg  input  2*p_nbits  {a = [63:32] (op1), b = [31:0] (op2)}
- respstream_val  output  1  response valid
- respstream_rdy  input  1  response ready
- respstream_msg  output  p_nbits  product, low p_nbits bits

Behaviour:
- Interface timing: one clock, clk. Reset is synchronous, active-high.
- Reset values:
  - Registers: state=IDLE; a_reg, b_reg, result_reg, shamt_cnt all 0.
  - Outputs: reqstream_rdy=1, respstream_val=0, respstream_msg=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - reqstream_rdy=1, respstream_val=0.
  - On reqstream_val&&rdy, latch a_reg=msg[63:32], b_reg=msg[31:0], result_reg=0, shamt_cnt=0; go to CALC.
- CALC (reqstream_rdy=0, respstream_val=0):
  - If b_reg==0 or shamt_cnt>=p_nbits: go to DONE; registers hold.
  - Else if b_reg[0]==1: result_reg += a_reg (mod 2^p_nbits); a_reg<<=1; b_reg>>=1; shamt_cnt+=1.
  - Else: s = trailing-zero count of b_reg[p_max_skip-1:0], saturated to p_max_skip; a_reg<<=s; b_reg>>=s; shamt_cnt+=s.
- DONE:
  - respstream_val=1, respstream_msg=result_reg, held stable until accepted; reqstream_rdy=0.
  - On respstream_rdy: go to IDLE.
- No overlap: the next request is accepted no earlier than the cycle after the response handshake.
- Latency, with accept at edge 0:
  - b=0: respstream_val asserts in cycle 2.
  - b=1: cycle 3.
  - Worst case (b=0xFFFFFFFF): cycle 34.
- shamt_cnt is 6 bits; termination uses shamt_cnt>=p_nbits.
- Signed and unsigned operands give identical low-half results; no sign handling is needed.
- respstream_msg is driven from result_reg only; no combinational path from reqstream_msg to respstream_msg.
- A reset in any state returns to IDLE next edge. Any in-flight transaction is dropped with no response.
- A request asserted in the same cycle as reset is ignored.
- Cycles with respstream_rdy low in DONE leave all state unchanged.

Decomposition:
- Shared package:
  - State encoding constants STATE_IDLE, STATE_CALC, STATE_DONE (2-bit).
  - Request/response width localparams.
- Natural split into control and datapath sub-module int_mul_iter_resp_dpath:
  - Contents: a_reg, b_reg, result_reg, shamt_cnt, shifters, adder, trailing-zero unit.
  - Outputs to FSM: b_is_zero, b_lsb, cnt_done.
  - The top-level file contains the FSM.

Test Plan:
- a=3, b=4 accepted at cycle 0; respstream_rdy=1 → respstream_val in cycle 4 (one skip of 2, one add, one b==0 check), msg=0x0000000C; reqstream_rdy=1 the cycle after the handshake.
- a=0x12345678, b=0 → respstream_val in cycle 2, msg=0x00000000.
- a=0xFFFFFFFF, b=0xFFFFFFFF → msg=0x00000001; respstream_val in cycle 34.
- a=2, b=0x80000000 → msg=0x00000000; 8 skip cycles before the add; respstream_val by cycle 12.
- a=7, b=6 with respstream_rdy held low 5 cycles in DONE → respstream_val=1 and msg=0x0000002A stable all 5 cycles; reqstream_rdy=0 throughout; returns to IDLE after rdy rises.
- Reset asserted in the 3rd CALC cycle of a=5, b=0xFF → next cycle respstream_val=0, reqstream_rdy=1. A follow-up request a=5, b=5 returns 0x00000019.
